// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one cacheline adaptor (256-bit line <-> 32-bit pmem beats) between
//   the I-cache and the D-cache. Requests from both caches are arbitrated. The
//   winner's command is latched onto the adaptor and held until ca_resp. The
//   returned line and a one-cycle resp pulse then go back to the winner only.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata  I-cache line request, held until i_resp
//   i_rdata, i_resp          line and one-cycle completion back to I-cache
//   d_read/d_write/d_addr/d_wdata  D-cache line request, held until d_resp
//   d_rdata, d_resp          line and one-cycle completion back to D-cache
//   ca_read/ca_write/ca_addr/ca_wdata  latched command to the adaptor
//   ca_rdata, ca_resp        line and one-cycle completion from the adaptor
//
// Configuration
//   PMEM_ARB_RR_EN  defined  : when both caches request, grant alternates with
//                              the previous grant.
//                   undefined: D has priority. I is granted once D has won
//                              MAX_D_STREAK times in a row while I waited.

module pmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              ca_read,
  output logic              ca_write,
  output logic [ADDR_W-1:0] ca_addr,
  output logic [LINE_W-1:0] ca_wdata,
  input  logic [LINE_W-1:0] ca_rdata,
  input  logic              ca_resp
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                grantD_q, grantD_d;
  logic                caRead_q, caRead_d;
  logic                caWrite_q, caWrite_d;
  logic [ADDR_W-1:0]   caAddr_q, caAddr_d;
  logic [LINE_W-1:0]   caWdata_q, caWdata_d;
  logic [LINE_W-1:0]   iRdata_q, iRdata_d;
  logic [LINE_W-1:0]   dRdata_q, dRdata_d;
  logic                iResp_q, iResp_d;
  logic                dResp_q, dResp_d;
  logic                iReq, dReq, pickD;

  assign iReq = i_read | i_write;
  assign dReq = d_read | d_write;

`ifdef PMEM_ARB_RR_EN
  logic lastGrantD_q, lastGrantD_d;

  // A contested grant goes to whichever side did not win last time.
  assign pickD = dReq & (~iReq | ~lastGrantD_q);
`else
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  logic [STREAK_W-1:0] dStreak_q, dStreak_d;

  // D wins a contested grant until it has won STREAK_MAX times in a row
  // while I was waiting.
  assign pickD = dReq & (~iReq | (dStreak_q < STREAK_MAX));
`endif

  // Next-state and output logic. Everything leaving the block is a register.
  always_comb begin
    state_d   = state_q;
    grantD_d  = grantD_q;
    caRead_d  = caRead_q;
    caWrite_d = caWrite_q;
    caAddr_d  = caAddr_q;
    caWdata_d = caWdata_q;
    iRdata_d  = iRdata_q;
    dRdata_d  = dRdata_q;
    iResp_d   = iResp_q;
    dResp_d   = dResp_q;
`ifdef PMEM_ARB_RR_EN
    lastGrantD_d = lastGrantD_q;
`else
    dStreak_d    = dStreak_q;
`endif
    case (state_q)
      IDLE: begin
        if (iReq | dReq) begin
          grantD_d = pickD;
          // If a cache raises both read and write, the write is taken.
          if (pickD) begin
            caWrite_d = d_write;
            caRead_d  = d_read & ~d_write;
            caAddr_d  = d_addr;
            caWdata_d = d_wdata;
          end else begin
            caWrite_d = i_write;
            caRead_d  = i_read & ~i_write;
            caAddr_d  = i_addr;
            caWdata_d = i_wdata;
          end
`ifdef PMEM_ARB_RR_EN
          lastGrantD_d = pickD;
`else
          // The streak counts only D wins that made I wait.
          if (pickD && iReq) begin
            if (dStreak_q != STREAK_MAX) dStreak_d = dStreak_q + STREAK_W'(1);
          end else begin
            dStreak_d = '0;
          end
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ca_resp) begin
          if (grantD_q) begin
            dRdata_d = ca_rdata;
            dResp_d  = 1'b1;
          end else begin
            iRdata_d = ca_rdata;
            iResp_d  = 1'b1;
          end
          caRead_d  = 1'b0;
          caWrite_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        iResp_d = 1'b0;
        dResp_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grantD_q  <= 1'b0;
      caRead_q  <= 1'b0;
      caWrite_q <= 1'b0;
      caAddr_q  <= '0;
      caWdata_q <= '0;
      iRdata_q  <= '0;
      dRdata_q  <= '0;
      iResp_q   <= 1'b0;
      dResp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grantD_q  <= grantD_d;
      caRead_q  <= caRead_d;
      caWrite_q <= caWrite_d;
      caAddr_q  <= caAddr_d;
      caWdata_q <= caWdata_d;
      iRdata_q  <= iRdata_d;
      dRdata_q  <= dRdata_d;
      iResp_q   <= iResp_d;
      dResp_q   <= dResp_d;
    end
  end

`ifdef PMEM_ARB_RR_EN
  // The first contested grant after reset goes to D.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lastGrantD_q <= 1'b0;
    else      lastGrantD_q <= lastGrantD_d;
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dStreak_q <= '0;
    else      dStreak_q <= dStreak_d;
  end
`endif

  assign i_rdata  = iRdata_q;
  assign i_resp   = iResp_q;
  assign d_rdata  = dRdata_q;
  assign d_resp   = dResp_q;
  assign ca_read  = caRead_q;
  assign ca_write = caWrite_q;
  assign ca_addr  = caAddr_q;
  assign ca_wdata = caWdata_q;

  // Protocol misuse checks. The design tolerates these conditions, but they
  // mean the cache or the adaptor is not behaving as expected.
  assert property (@(posedge clk) disable iff (!rst) !(i_read && i_write));
  assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
  assert property (@(posedge clk) disable iff (!rst) ca_resp |-> (state_q == BUSY));

endmodule
